// File: rtl/cpu_wr_fifo.sv
// Captures qualified CPU bus writes (filtered M2 falling edge) into a DEPTH-entry FIFO.
// Push lands M2_FILT+1 edges after the first synchronizer sees M2 low; full without pop drops and sets sticky ovf.
module cpu_wr_fifo #(
  parameter int DEPTH   = 4,
  parameter int M2_FILT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m2,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic [15:0] win_match,
  input  logic [15:0] win_mask,
  input  logic        wr_ready,
  input  logic        ovf_clr,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [4:0]  level,
  output logic        ovf
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [2:0]  FILT    = 3'(M2_FILT);
  localparam logic [4:0]  DEPTH_L = 5'(DEPTH);

  logic          m2_s1_q, m2_s2_q;
  logic          rw_s1_q, rw_s2_q;
  logic [15:0]   addr_s1_q, addr_s2_q;
  logic [7:0]    data_s1_q, data_s2_q;
  logic          m2_f_q, m2_f_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          cap_rw_q;
  logic [15:0]   cap_addr_q;
  logic [7:0]    cap_data_q;
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    level_q, level_d;
  logic          wr_valid_q;
  logic          ovf_q, ovf_d;
  logic          fall_evt, push, full, pop, push_ok, ovf_set;

  // Bus signals ride the same two-stage pipe as m2 so they stay sample-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_s1_q   <= 1'b0;
      m2_s2_q   <= 1'b0;
      rw_s1_q   <= 1'b0;
      rw_s2_q   <= 1'b0;
      addr_s1_q <= '0;
      addr_s2_q <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      m2_s1_q   <= m2;
      m2_s2_q   <= m2_s1_q;
      rw_s1_q   <= cpu_rw;
      rw_s2_q   <= rw_s1_q;
      addr_s1_q <= cpu_addr;
      addr_s2_q <= addr_s1_q;
      data_s1_q <= cpu_data;
      data_s2_q <= data_s1_q;
    end
  end

  always_comb begin
    m2_f_d = m2_f_q;
    cnt_d  = 3'd0;
    if (m2_s2_q != m2_f_q) begin
      if (cnt_q + 3'd1 == FILT) begin
        m2_f_d = m2_s2_q;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  // The event fires on the same edge m2_f drops, which gives the k+M2_FILT+1 push timing.
  assign fall_evt = m2_f_q && !m2_f_d;
  assign push     = fall_evt && !cap_rw_q && (((cap_addr_q ^ win_match) & win_mask) == 16'h0000);
  assign full     = (level_q == DEPTH_L);
  assign pop      = wr_valid_q && wr_ready;
  assign push_ok  = push && (!full || pop);
  assign ovf_set  = push && full && !pop;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + 5'd1;
    end else if (!push_ok && pop) begin
      level_d = level_q - 5'd1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_f_q     <= 1'b0;
      cnt_q      <= 3'd0;
      cap_rw_q   <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
    end else begin
      m2_f_q <= m2_f_d;
      cnt_q  <= cnt_d;
      if (m2_s2_q) begin
        cap_rw_q   <= rw_s2_q;
        cap_addr_q <= addr_s2_q;
        cap_data_q <= data_s2_q;
      end
    end
  end

  // Storage is cleared on reset so the head outputs read zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wr_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {cap_addr_q, cap_data_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q    <= level_d;
      wr_valid_q <= (level_d != 5'd0);
      ovf_q      <= ovf_d;
    end
  end

  assign {wr_addr, wr_data} = mem_q[rd_ptr_q];
  assign wr_valid = wr_valid_q;
  assign level    = level_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_cpu_wr_fifo.sv
// Directed bench for cpu_wr_fifo: latency, address filtering, overflow, full+pop, glitch rejection, reset.
module tb_cpu_wr_fifo;

  logic        clk;
  logic        rst_n;
  logic        m2;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic [15:0] win_match;
  logic [15:0] win_mask;
  logic        wr_ready;
  logic        ovf_clr;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  level;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  cpu_wr_fifo #(.DEPTH(4), .M2_FILT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m2        (m2),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .win_match (win_match),
    .win_mask  (win_mask),
    .wr_ready  (wr_ready),
    .ovf_clr   (ovf_clr),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .level     (level),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // M2 high phase with bus values, then drop M2; returns 2ns after the edge preceding edge k.
  task automatic write_pre(input logic rw, input logic [15:0] addr, input logic [7:0] data);
    cpu_rw   = rw;
    cpu_addr = addr;
    cpu_data = data;
    m2       = 1'b1;
    repeat (5) @(posedge clk);
    #2 m2 = 1'b0;
  endtask

  task automatic bus_cycle(input logic rw, input logic [15:0] addr, input logic [7:0] data);
    write_pre(rw, addr, data);
    repeat (5) @(posedge clk);
    #2;
  endtask

  task automatic pop_one(input string tag, input logic [15:0] ea, input logic [7:0] ed);
    check({tag, "_vld"}, 32'(wr_valid), 1);
    check({tag, "_addr"}, 32'(wr_addr), 32'(ea));
    check({tag, "_data"}, 32'(wr_data), 32'(ed));
    wr_ready = 1'b1;
    @(posedge clk);
    #2 wr_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    m2        = 1'b0;
    cpu_rw    = 1'b1;
    cpu_addr  = '0;
    cpu_data  = '0;
    win_match = 16'h6000;
    win_mask  = 16'hF000;
    wr_ready  = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    check("rst_vld",   32'(wr_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf",   32'(ovf), 0);
    check("rst_addr",  32'(wr_addr), 0);
    check("rst_data",  32'(wr_data), 0);

    // Single write with ready high: visible exactly between edges k+3 and k+4.
    wr_ready = 1'b1;
    write_pre(1'b0, 16'h6000, 8'h35);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("lat_vld_e%0d", i), 32'(wr_valid), (i == 3) ? 1 : 0);
      if (i == 3) begin
        check("lat_addr",  32'(wr_addr), 32'h6000);
        check("lat_data",  32'(wr_data), 32'h35);
        check("lat_level", 32'(level), 1);
      end
    end
    check("lat_level_end", 32'(level), 0);
    wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Out-of-window write and a read must not push.
    bus_cycle(1'b0, 16'h7000, 8'h12);
    bus_cycle(1'b1, 16'h6000, 8'h99);
    check("nomatch_level", 32'(level), 0);
    check("nomatch_vld",   32'(wr_valid), 0);

    // Overflow: five writes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      bus_cycle(1'b0, 16'h6000 + 16'(i), 8'(i));
    end
    check("ovf_level", 32'(level), 4);
    check("ovf_flag",  32'(ovf), 1);
    repeat (3) @(posedge clk);
    #2;
    check("hold_data", 32'(wr_data), 32'h01);
    pop_one("ovf_pop1", 16'h6001, 8'h01);
    pop_one("ovf_pop2", 16'h6002, 8'h02);
    pop_one("ovf_pop3", 16'h6003, 8'h03);
    pop_one("ovf_pop4", 16'h6004, 8'h04);
    check("ovf_drain_level", 32'(level), 0);
    check("ovf_drain_vld",   32'(wr_valid), 0);
    check("ovf_still_set",   32'(ovf), 1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #2 ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 0);

    // Full with simultaneous pop on the push edge.
    for (int i = 1; i <= 4; i++) begin
      bus_cycle(1'b0, 16'h6010 + 16'(i), 8'hA0 + 8'(i));
    end
    check("fullpop_pre_level", 32'(level), 4);
    write_pre(1'b0, 16'h6020, 8'h06);
    repeat (3) @(posedge clk);
    #2 wr_ready = 1'b1;
    @(posedge clk);
    #2 wr_ready = 1'b0;
    check("fullpop_level", 32'(level), 4);
    check("fullpop_ovf",   32'(ovf), 0);
    repeat (2) @(posedge clk);
    #2;
    pop_one("fullpop_a2", 16'h6012, 8'hA2);
    pop_one("fullpop_a3", 16'h6013, 8'hA3);
    pop_one("fullpop_a4", 16'h6014, 8'hA4);
    pop_one("fullpop_06", 16'h6020, 8'h06);
    check("fullpop_empty", 32'(level), 0);

    // One-cycle M2 low glitch must be filtered out.
    cpu_rw   = 1'b0;
    cpu_addr = 16'h6030;
    cpu_data = 8'h77;
    m2       = 1'b1;
    repeat (5) @(posedge clk);
    #2 m2 = 1'b0;
    @(posedge clk);
    #2 m2 = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("glitch_level", 32'(level), 0);
    m2 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("glitch_clean_level", 32'(level), 1);
    pop_one("glitch_pop", 16'h6030, 8'h77);
    check("glitch_empty", 32'(level), 0);

    // Asynchronous reset with three queued entries and one write in flight.
    bus_cycle(1'b0, 16'h6041, 8'h41);
    bus_cycle(1'b0, 16'h6042, 8'h42);
    bus_cycle(1'b0, 16'h6043, 8'h43);
    check("rst3_level", 32'(level), 3);
    write_pre(1'b0, 16'h6044, 8'h44);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld",   32'(wr_valid), 0);
    check("arst_level", 32'(level), 0);
    check("arst_addr",  32'(wr_addr), 0);
    check("arst_data",  32'(wr_data), 0);
    check("arst_ovf",   32'(ovf), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check("post_rst_level", 32'(level), 0);
    check("post_rst_vld",   32'(wr_valid), 0);
    bus_cycle(1'b0, 16'h6055, 8'h88);
    check("post_rst_push_level", 32'(level), 1);
    pop_one("post_rst_pop", 16'h6055, 8'h88);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
